// File: rtl/a2b_share_feeder_n4_pkg.sv
// Shared types and defaults for the 4-share A2B feeder.
// Contents: FSM state enum, share slice helper, default sizing constants.
package a2b_share_feeder_n4_pkg;

   localparam int unsigned K_WIDTH_DEF      = 32;
   localparam int unsigned N_SHARES_DEF     = 4;
   localparam int unsigned MAX_INFLIGHT_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REFRESH = 2'd1,
      ISSUE   = 2'd2
   } feed_state_e;

   // Bit offset of share idx within a packed share bus.
   function automatic int unsigned share_lsb(input int unsigned idx, input int unsigned kw);
      return idx * kw;
   endfunction

endpackage

// File: rtl/a2b_share_feeder_n4_if.sv
// Handshake/bus bundle between the share feeder, its upstream, the
// randomness source and the A2B converter.
// Signals: in_vld/in_rdy/in_a (word in), rnd_vld/rnd_rdy/rnd (randomness),
//          o_a/o_dvld (issue to converter), a2b_ovld (converter done).
// slave = feeder view, master = environment view.
interface a2b_share_feeder_n4_if #(
   parameter int unsigned K_WIDTH  = 32,
   parameter int unsigned N_SHARES = 4
);
   localparam int unsigned MASKWIDTH = K_WIDTH * N_SHARES;

   logic                 in_vld;
   logic                 in_rdy;
   logic [MASKWIDTH-1:0] in_a;
   logic                 rnd_vld;
   logic                 rnd_rdy;
   logic [K_WIDTH-1:0]   rnd;
   logic [MASKWIDTH-1:0] o_a;
   logic                 o_dvld;
   logic                 a2b_ovld;

   modport slave (
      input  in_vld, in_a, rnd_vld, rnd, a2b_ovld,
      output in_rdy, rnd_rdy, o_a, o_dvld
   );

   modport master (
      output in_vld, in_a, rnd_vld, rnd, a2b_ovld,
      input  in_rdy, rnd_rdy, o_a, o_dvld
   );

endinterface

// File: rtl/a2b_credit_cnt.sv
// Saturating up/down counter of issued-but-unreturned conversions.
// Ports: clk, rst (sync, active-high), ena (freeze when low),
//        inc (word issued), dec (converter returned a word),
//        cnt (outstanding count), full (cnt == MAX_CNT).
module a2b_credit_cnt #(
   parameter  int unsigned MAX_CNT = 8,
   localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             full
);

   logic [CNT_W-1:0] cnt_d;
   logic             dec_ok;

   // A return with nothing outstanding is spurious and dropped.
   always_comb begin
      cnt_d  = cnt;
      dec_ok = dec && (cnt != '0);
      case ({inc, dec_ok})
         2'b10:   if (cnt != CNT_W'(MAX_CNT)) cnt_d = cnt + CNT_W'(1);
         2'b01:   cnt_d = cnt - CNT_W'(1);
         default: cnt_d = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         full <= 1'b0;
      end else if (ena) begin
         cnt  <= cnt_d;
         full <= (cnt_d == CNT_W'(MAX_CNT));
      end
   end

endmodule

// File: rtl/a2b_share_feeder_n4.sv
// Upstream feeder for the 4-share arithmetic-to-Boolean converter: accepts a
// masked word, refreshes its shares with one random word per round, then
// issues the shares with a one-cycle o_dvld pulse. In-flight conversions are
// bounded by a credit counter returned through a2b_ovld.
// Ports: clk, rst (sync, active-high), ena (global freeze when low),
//        bus (a2b_share_feeder_n4_if.slave), inflight (outstanding count),
//        busy (FSM active or credits outstanding).
// Build option: A2B_FEED_ZEROIZE_EN clears share regs and o_a the cycle
// after each issue; otherwise o_a retains the last issued shares.
module a2b_share_feeder_n4
   import a2b_share_feeder_n4_pkg::*;
#(
   parameter int unsigned K_WIDTH      = K_WIDTH_DEF,
   parameter int unsigned N_SHARES     = N_SHARES_DEF,
   parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                ena,
   a2b_share_feeder_n4_if.slave                bus,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
   output logic                                busy
);

   localparam int unsigned MASKWIDTH = K_WIDTH * N_SHARES;
   localparam int unsigned J_W       = (N_SHARES > 2) ? $clog2(N_SHARES) : 1;

   feed_state_e          state_q, state_d;
   logic [J_W-1:0]       j_q, j_d;
   logic [K_WIDTH-1:0]   share_q [N_SHARES];
   logic [K_WIDTH-1:0]   share_d [N_SHARES];
   logic [MASKWIDTH-1:0] oa_q, oa_d;
   logic                 in_rdy_c;
   logic                 rnd_rdy_c;
   logic                 dvld_c;
   logic                 cnt_full;

   // Next-state, share datapath and handshake strobes.
   always_comb begin
      state_d   = state_q;
      j_d       = j_q;
      share_d   = share_q;
      oa_d      = oa_q;
      in_rdy_c  = 1'b0;
      rnd_rdy_c = 1'b0;
      dvld_c    = 1'b0;

      case (state_q)
         IDLE: begin
            // Depends only on registered state, never on in_vld.
            in_rdy_c = ena && !rst && !cnt_full;
            if (in_rdy_c && bus.in_vld) begin
               for (int unsigned i = 0; i < N_SHARES; i++)
                  share_d[i] = bus.in_a[share_lsb(i, K_WIDTH) +: K_WIDTH];
               j_d     = J_W'(1);
               state_d = REFRESH;
            end
         end

         REFRESH: begin
            rnd_rdy_c = ena && !rst && bus.rnd_vld;
            if (rnd_rdy_c) begin
               // Move rnd from share0 into share j: sum mod 2^K unchanged.
               share_d[0]   = share_q[0] - bus.rnd;
               share_d[j_q] = share_q[j_q] + bus.rnd;
               j_d          = j_q + J_W'(1);
               if (j_q == J_W'(N_SHARES - 1)) begin
                  state_d = ISSUE;
                  for (int unsigned i = 0; i < N_SHARES; i++)
                     oa_d[share_lsb(i, K_WIDTH) +: K_WIDTH] = share_d[i];
               end
            end
         end

         ISSUE: begin
            dvld_c = ena && !rst;
            if (dvld_c) begin
               state_d = IDLE;
`ifdef A2B_FEED_ZEROIZE_EN
               share_d = '{default: '0};
               oa_d    = '0;
`endif
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and share registers; the comb block already holds when ena is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         j_q     <= '0;
         share_q <= '{default: '0};
         oa_q    <= '0;
      end else if (ena) begin
         state_q <= state_d;
         j_q     <= j_d;
         share_q <= share_d;
         oa_q    <= oa_d;
      end
   end

   a2b_credit_cnt #(
      .MAX_CNT (MAX_INFLIGHT)
   ) u_credit (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .inc  (dvld_c),
      .dec  (bus.a2b_ovld),
      .cnt  (inflight),
      .full (cnt_full)
   );

   assign bus.in_rdy  = in_rdy_c;
   assign bus.rnd_rdy = rnd_rdy_c;
   assign bus.o_dvld  = dvld_c;
   assign bus.o_a     = oa_q;
   assign busy        = (state_q != IDLE) || (inflight != '0);

endmodule

// File: tb/tb_a2b_share_feeder_n4.sv
// Directed self-checking bench for a2b_share_feeder_n4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_a2b_share_feeder_n4;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [3:0] inflight;
   logic       busy;

   int n_tests;
   int n_fail;

   a2b_share_feeder_n4_if #(.K_WIDTH(32), .N_SHARES(4)) bus ();

   a2b_share_feeder_n4 dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .bus      (bus),
      .inflight (inflight),
      .busy     (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] share_sum(input logic [127:0] v);
      return v[31:0] + v[63:32] + v[95:64] + v[127:96];
   endfunction

   task automatic pulse_ovld(input int n);
      for (int k = 0; k < n; k++) begin
         bus.a2b_ovld = 1'b1;
         @(negedge clk);
      end
      bus.a2b_ovld = 1'b0;
   endtask

   // One transaction from IDLE; returns issue latency (cycles after accept)
   // and the issued shares, and leaves the bench one cycle past ISSUE.
   task automatic send_word(input logic [127:0] a, input logic [31:0] r0, r1, r2,
                            input int stall_len, input int ena_len, input bit ovld_at_issue,
                            output int lat, output logic [127:0] oa);
      logic [31:0] rv [3];
      int guard;
      rv[0] = r0; rv[1] = r1; rv[2] = r2;
      #1 check("in_rdy_idle", 128'(bus.in_rdy), 128'(1));
      bus.in_vld  = 1'b1;
      bus.in_a    = a;
      bus.rnd_vld = 1'b0;
      @(negedge clk);
      bus.in_vld = 1'b0;
      lat = 1;
      #1 check("busy_active", 128'(busy), 128'(1));
      for (int k = 0; k < stall_len; k++) begin
         bus.rnd_vld = 1'b0;
         #1 if (k == 0) check("stall_rnd_rdy", 128'(bus.rnd_rdy), 128'(0));
         @(negedge clk);
         lat++;
      end
      for (int r = 0; r < 3; r++) begin
         if (r == 1) begin
            for (int k = 0; k < ena_len; k++) begin
               ena          = 1'b0;
               bus.rnd_vld  = 1'b1;
               bus.rnd      = 32'hDEADBEEF;
               bus.a2b_ovld = 1'b1;
               #1 if (k == 0) begin
                  check("ena_lo_rnd_rdy", 128'(bus.rnd_rdy), 128'(0));
                  check("ena_lo_in_rdy", 128'(bus.in_rdy), 128'(0));
                  check("ena_lo_dvld", 128'(bus.o_dvld), 128'(0));
               end
               @(negedge clk);
               lat++;
            end
            ena          = 1'b1;
            bus.a2b_ovld = 1'b0;
         end
         bus.rnd_vld = 1'b1;
         bus.rnd     = rv[r];
         #1 if (r == 0) check("rnd_rdy", 128'(bus.rnd_rdy), 128'(1));
         @(negedge clk);
         lat++;
      end
      bus.rnd_vld = 1'b0;
      guard = 0;
      #1;
      while (!bus.o_dvld && guard < 8) begin
         @(negedge clk);
         #1;
         lat++;
         guard++;
      end
      check("dvld_seen", 128'(bus.o_dvld), 128'(1));
      oa = bus.o_a;
      if (ovld_at_issue) bus.a2b_ovld = 1'b1;
      @(negedge clk);
      bus.a2b_ovld = 1'b0;
      #1 check("dvld_one_cycle", 128'(bus.o_dvld), 128'(0));
   endtask

   initial begin
      int          lat;
      logic [127:0] oa;
      logic [127:0] exp_post;

      n_tests      = 0;
      n_fail       = 0;
      rst          = 1'b1;
      ena          = 1'b1;
      bus.in_vld   = 1'b0;
      bus.in_a     = '0;
      bus.rnd_vld  = 1'b0;
      bus.rnd      = '0;
      bus.a2b_ovld = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_rdy", 128'(bus.in_rdy), 128'(0));
      check("rst_rnd_rdy", 128'(bus.rnd_rdy), 128'(0));
      check("rst_dvld", 128'(bus.o_dvld), 128'(0));
      check("rst_o_a", bus.o_a, 128'(0));
      check("rst_inflight", 128'(inflight), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      @(negedge clk);

      // Single word, rnd held high
      send_word({32'h0, 32'h0, 32'h0, 32'h12345678}, 32'h1, 32'h2, 32'h3, 0, 0, 1'b0, lat, oa);
      check("t1_latency", 128'(lat), 128'(4));
      check("t1_o_a", oa, {32'h3, 32'h2, 32'h1, 32'h12345672});
      check("t1_sum", 128'(share_sum(oa)), 128'(32'h12345678));
      check("t1_inflight", 128'(inflight), 128'(1));
`ifdef A2B_FEED_ZEROIZE_EN
      exp_post = '0;
`else
      exp_post = {32'h3, 32'h2, 32'h1, 32'h12345672};
`endif
      check("t1_o_a_after", bus.o_a, exp_post);

      // Wrap-around through zero (back-to-back accept)
      send_word('0, 32'hFFFFFFFF, 32'h10, 32'h80000000, 0, 0, 1'b0, lat, oa);
      check("t2_o_a", oa, {32'h80000000, 32'h10, 32'hFFFFFFFF, 32'h7FFFFFF1});
      check("t2_sum", 128'(share_sum(oa)), 128'(0));
      check("t2_inflight", 128'(inflight), 128'(2));

      // Randomness stall of 5 cycles
      send_word({32'h4, 32'h3, 32'h2, 32'h1}, 32'h10, 32'h20, 32'h30, 5, 0, 1'b0, lat, oa);
      check("t3_latency", 128'(lat), 128'(9));
      check("t3_o_a", oa, {32'h34, 32'h23, 32'h12, 32'hFFFFFFA1});
      check("t3_sum", 128'(share_sum(oa)), 128'(32'hA));

      // ena low for 3 cycles mid-REFRESH (a2b_ovld held meanwhile, must be ignored)
      send_word({32'h44, 32'h33, 32'h22, 32'h11}, 32'h5, 32'h6, 32'h7, 0, 3, 1'b0, lat, oa);
      check("t4_latency", 128'(lat), 128'(7));
      check("t4_o_a", oa, {32'h4B, 32'h39, 32'h27, 32'hFFFFFFFF});
      check("t4_sum", 128'(share_sum(oa)), 128'(32'hAA));
      check("t4_inflight", 128'(inflight), 128'(4));

      // Return all credits, then one spurious return
      pulse_ovld(4);
      #1 check("cr_zero", 128'(inflight), 128'(0));
      pulse_ovld(1);
      #1 check("cr_sat_zero", 128'(inflight), 128'(0));
      check("cr_busy_idle", 128'(busy), 128'(0));

      // Fill all 8 credits
      for (int w = 0; w < 8; w++)
         send_word({32'(w), 32'h0, 32'h0, 32'h0}, 32'(w), 32'h1, 32'h2, 0, 0, 1'b0, lat, oa);
      #1;
      check("full_inflight", 128'(inflight), 128'(8));
      check("full_in_rdy", 128'(bus.in_rdy), 128'(0));
      bus.in_vld = 1'b1;
      repeat (2) @(negedge clk);
      bus.in_vld = 1'b0;
      #1;
      check("full_no_accept", 128'(inflight), 128'(8));
      check("full_no_busy_fsm", 128'(bus.rnd_rdy), 128'(0));
      pulse_ovld(1);
      #1;
      check("full_ret_inflight", 128'(inflight), 128'(7));
      check("full_ret_in_rdy", 128'(bus.in_rdy), 128'(1));

      // Issue and return in the same cycle
      send_word({32'h1, 32'h1, 32'h1, 32'h1}, 32'h1, 32'h1, 32'h1, 0, 0, 1'b1, lat, oa);
      check("same_cycle_inflight", 128'(inflight), 128'(7));
      pulse_ovld(4);
      #1 check("pre_rst_inflight", 128'(inflight), 128'(3));

      // Reset in REFRESH with 3 credits outstanding
      bus.in_vld  = 1'b1;
      bus.in_a    = {32'h9, 32'h8, 32'h7, 32'h6};
      @(negedge clk);
      bus.in_vld  = 1'b0;
      bus.rnd_vld = 1'b1;
      bus.rnd     = 32'h55;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("mid_rst_o_a", bus.o_a, 128'(0));
      check("mid_rst_dvld", 128'(bus.o_dvld), 128'(0));
      check("mid_rst_in_rdy", 128'(bus.in_rdy), 128'(0));
      check("mid_rst_rnd_rdy", 128'(bus.rnd_rdy), 128'(0));
      check("mid_rst_inflight", 128'(inflight), 128'(0));
      check("mid_rst_busy", 128'(busy), 128'(0));
      rst = 1'b0;
      bus.rnd_vld = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_in_rdy", 128'(bus.in_rdy), 128'(1));
      check("post_rst_busy", 128'(busy), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/a2b_share_feeder_n4.md
Name: a2b_share_feeder_n4

Overview:
- Upstream feeder for the 4-share arithmetic-to-Boolean converter.
- Accepts one arithmetically masked word (N_SHARES shares, sum mod 2^K_WIDTH) per transaction over valid/ready.
- Refreshes the shares sequentially with fresh randomness, then issues them to the converter as a single-cycle dvld pulse.
- Bounds in-flight conversions with a credit counter that is returned by the converter's ovld.

Parameters:
- K_WIDTH, 32, width of one share in bits.
- N_SHARES, 4, number of arithmetic shares.
- MASKWIDTH, K_WIDTH*N_SHARES, packed share bus width; share i occupies bits [i*K_WIDTH +: K_WIDTH].
- MAX_INFLIGHT, 8, maximum number of issued words not yet returned by converter ovld.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- ena  input  1  global enable; when low, all state freezes.
- in_vld  input  1  upstream word valid.
- in_rdy  output  1  block can accept a word.
- in_a  input  MASKWIDTH  arithmetic shares of the input word.
- rnd_vld  input  1  fresh random word available.
- rnd_rdy  output  1  random word consumed this cycle.
- rnd  input  K_WIDTH  refresh randomness.
- o_a  output  MASKWIDTH  refreshed shares, drives converter i_a.
- o_dvld  output  1  one-cycle issue pulse, drives converter dvld.
- a2b_ovld  input  1  converter ovld; returns one credit.
- inflight  output  $clog2(MAX_INFLIGHT+1)  outstanding conversion count.
- busy  output  1  FSM not in IDLE, or inflight != 0.

Behaviour:
- Reset: synchronous, active-high, on the clk rising edge.
  - FSM = IDLE, share regs = 0, o_a = 0, o_dvld = 0, in_rdy = 0 during reset, rnd_rdy = 0, inflight = 0, busy = 0.
  - Reset mid-operation discards the word and all credits.
- ena = 0: no state change, no handshake completes; in_rdy, rnd_rdy and o_dvld are forced to 0.
- FSM states: IDLE, REFRESH, ISSUE.
- IDLE:
  - in_rdy = 1 when inflight < MAX_INFLIGHT.
  - On in_vld & in_rdy: latch in_a into share regs, set round counter j = 1, go to REFRESH.
- REFRESH:
  - rnd_rdy = rnd_vld.
  - On rnd_vld: share0 <= share0 - rnd, share_j <= share_j + rnd, both mod 2^K_WIDTH; j++.
  - When j = N_SHARES-1 is consumed, go to ISSUE.
  - rnd_vld = 0 stalls the FSM in place, with no share change.
- ISSUE:
  - o_dvld = 1 for exactly one cycle; o_a holds the refreshed shares; inflight increments; go to IDLE.
  - o_a stays stable until the next ISSUE, or until cleared under the optional feature.
- Invariant: sum of shares mod 2^K_WIDTH is identical at latch and at issue.
- Latency with rnd_vld held high: accept at cycle t, REFRESH cycles t+1..t+N_SHARES-1, o_dvld at cycle t+N_SHARES. Throughput is one word per N_SHARES+1 cycles.
- Credit counter:
  - +1 on o_dvld, -1 on a2b_ovld; both in the same cycle leaves it unchanged.
  - a2b_ovld with inflight = 0 is ignored, so the counter saturates at 0.
  - inflight = MAX_INFLIGHT deasserts in_rdy; the counter never exceeds MAX_INFLIGHT.
- Back-to-back: a word can be accepted in the cycle after ISSUE.
- No combinational path from in_vld to in_rdy.

Optional Feature:
- Macro: A2B_FEED_ZEROIZE_EN.
- Defined: one cycle after the o_dvld pulse, share regs and o_a are cleared to 0. The converter samples o_a on the dvld cycle only.
- Undefined: o_a retains the last issued shares.

Decomposition:
- Shared package holds:
  - FSM state typedef: IDLE, REFRESH, ISSUE.
  - Share slice index helper.
  - Default constants for K_WIDTH, N_SHARES and MAX_INFLIGHT.
- One sub-module: a2b_credit_cnt, the saturating up/down inflight counter with a full flag. The FSM and share datapath stay in the top level.

Test Plan:
- Single word, rnd_vld held high: in_a = {0,0,0,0x12345678}, rnd sequence 0x1,0x2,0x3 -> o_dvld at t+4, o_a = {3,2,1,0x12345672}, sum = 0x12345678.
- Wrap-around: share0 = 0, rnd = 0xFFFFFFFF -> share0 = 0x00000001 after round 1, sum of shares preserved mod 2^32.
- Randomness stall: rnd_vld low for 5 cycles during REFRESH -> shares unchanged, rnd_rdy = 0, o_dvld delayed by exactly 5 cycles.
- Credit full: issue 8 words with a2b_ovld = 0 -> inflight = 8, in_rdy = 0. Then one a2b_ovld pulse -> inflight = 7, in_rdy = 1. o_dvld and a2b_ovld in the same cycle -> inflight unchanged.
- ena low mid-REFRESH for 3 cycles -> no state or share change and no handshakes; on resume, o_a matches the ena = 1 reference.
- rst asserted in REFRESH with inflight = 3 -> next cycle all outputs 0, FSM in IDLE. With A2B_FEED_ZEROIZE_EN defined, o_a = 0 one cycle after each o_dvld.
